// File: rtl/isram_pkg.sv
// -----------------------------------------------------------------------------
// isram_pkg
// Shared definitions for the instruction-SRAM port arbiter:
//   - isram_state_e : arbiter state encoding
//   - DATA_W        : SRAM data width (one 64-bit doubleword)
//   - lane_bwe()    : places a 4-bit word byte-enable into the selected half
//   - lane_rdata()  : extracts the selected 32-bit half of a doubleword
// -----------------------------------------------------------------------------
package isram_pkg;

    localparam int unsigned DATA_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LS_ACC = 2'd1,
        ST_LS_RSP = 2'd2,
        ST_LS_GAP = 2'd3
    } isram_state_e;

    // hi_i selects the upper 32-bit half (byte lanes 7..4) of the doubleword.
    function automatic logic [7:0] lane_bwe(input logic hi_i, input logic [3:0] be_i);
        logic [7:0] bwe;
        if (hi_i) begin
            bwe = {be_i, 4'b0000};
        end else begin
            bwe = {4'b0000, be_i};
        end
        return bwe;
    endfunction

    function automatic logic [31:0] lane_rdata(input logic hi_i, input logic [63:0] data_i);
        logic [31:0] word;
        if (hi_i) begin
            word = data_i[63:32];
        end else begin
            word = data_i[31:0];
        end
        return word;
    endfunction

endpackage

// File: rtl/isram_rdhold.sv
// -----------------------------------------------------------------------------
// isram_rdhold
// Fetch read-data path. In the cycle after a fetch access the SRAM output is
// passed straight through; the same value is captured so the fetch unit keeps
// seeing it until the next fetch access completes.
//   clk, cpurst_n : clock, synchronous active-low reset
//   issue_i       : a fetch access is presented to the SRAM this cycle
//   rdata_i       : SRAM read data
//   data_o        : instruction data towards the fetch unit
// -----------------------------------------------------------------------------
module isram_rdhold
    import isram_pkg::*;
(
    input  logic              clk,
    input  logic              cpurst_n,
    input  logic              issue_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q;
    logic [DATA_W-1:0] hold_q;

    // Track the fetch-data cycle and capture the returned doubleword in it.
    always_ff @(posedge clk) begin
        if (!cpurst_n) begin
            valid_q <= 1'b0;
            hold_q  <= {DATA_W{1'b0}};
        end else begin
            valid_q <= issue_i;
            if (valid_q) begin
                hold_q <= rdata_i;
            end
        end
    end

    // Live SRAM data in the fetch-data cycle, held copy otherwise.
    always_comb begin
        data_o = {DATA_W{1'b0}};
        if (!cpurst_n) begin
            data_o = {DATA_W{1'b0}};
        end else if (valid_q) begin
            data_o = rdata_i;
        end else begin
            data_o = hold_q;
        end
    end

endmodule

// File: rtl/isram_port.sv
// -----------------------------------------------------------------------------
// isram_port
// Shares one single-port synchronous instruction SRAM between the fetch unit
// and the load/store unit. Load/store wins a simultaneous request, and after
// every load/store transaction one gap slot is reserved for fetch.
//   clk, cpurst_n              : clock, synchronous active-low reset
//   isram_cs, isram_adr        : fetch read request and doubleword address
//   instr_fromsram             : fetch data (latency 1, then held)
//   lr_req/we/adr/be/wdata     : load/store request, held until lr_ack
//   lr_ack, lr_rdata, lr_err   : completion pulse, load data, range error
//   lr_isram_cs                : load/store currently owns the SRAM port
//   sram_*                     : SRAM macro interface
// -----------------------------------------------------------------------------
module isram_port
    import isram_pkg::*;
#(
    parameter int unsigned ADDR_W = 13,
    parameter logic [31:0] BASE   = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              cpurst_n,
    input  logic              isram_cs,
    input  logic [31:3]       isram_adr,
    output logic [DATA_W-1:0] instr_fromsram,
    input  logic              lr_req,
    input  logic              lr_we,
    input  logic [31:2]       lr_adr,
    input  logic [3:0]        lr_be,
    input  logic [31:0]       lr_wdata,
    output logic              lr_ack,
    output logic [31:0]       lr_rdata,
    output logic              lr_err,
    output logic              lr_isram_cs,
    output logic              sram_ce,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_adr,
    output logic [7:0]        sram_bwe,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    isram_state_e      state_q;
    logic              we_q;
    logic              err_q;
    logic              lane_q;
    logic [ADDR_W-1:0] adr_q;
    logic [3:0]        be_q;
    logic [31:0]       wdata_q;

    logic [31:0]       lr_off_s;
    logic              lr_oor_s;
    logic              fetch_go_s;
    logic              ls_go_s;
    logic              unused_s;

    // Byte offset from the SRAM base; anything beyond the array is an error.
    assign lr_off_s = {lr_adr, 2'b00} - BASE;
    assign lr_oor_s = (lr_off_s >> (ADDR_W + 3)) != 32'd0;
    assign unused_s = ^isram_adr[31:ADDR_W+3];

    // Fetch is served in IDLE when no load/store competes, and always in GAP.
    assign fetch_go_s = cpurst_n && isram_cs &&
                        (((state_q == ST_IDLE) && !lr_req) || (state_q == ST_LS_GAP));
    assign ls_go_s    = cpurst_n && (state_q == ST_LS_ACC) && !err_q;

    // Arbiter FSM; the load/store request is captured when it is accepted.
    always_ff @(posedge clk) begin
        if (!cpurst_n) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            lane_q  <= 1'b0;
            adr_q   <= {ADDR_W{1'b0}};
            be_q    <= 4'b0000;
            wdata_q <= 32'h0000_0000;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (lr_req) begin
                        state_q <= ST_LS_ACC;
                        we_q    <= lr_we;
                        err_q   <= lr_oor_s;
                        lane_q  <= lr_adr[2];
                        adr_q   <= lr_adr[ADDR_W+2:3];
                        be_q    <= lr_be;
                        wdata_q <= lr_wdata;
                    end
                end
                ST_LS_ACC: begin
                    if (we_q || err_q) begin
                        state_q <= ST_LS_GAP;
                    end else begin
                        state_q <= ST_LS_RSP;
                    end
                end
                ST_LS_RSP: state_q <= ST_LS_GAP;
                ST_LS_GAP: state_q <= ST_IDLE;
                default:   state_q <= ST_IDLE;
            endcase
        end
    end

    // SRAM command: load/store access in LS_ACC, otherwise a granted fetch.
    always_comb begin
        sram_ce    = 1'b0;
        sram_we    = 1'b0;
        sram_adr   = isram_adr[ADDR_W+2:3];
        sram_bwe   = 8'h00;
        sram_wdata = {wdata_q, wdata_q};
        if (ls_go_s) begin
            sram_ce  = 1'b1;
            sram_we  = we_q;
            sram_adr = adr_q;
            if (we_q) begin
                sram_bwe = lane_bwe(lane_q, be_q);
            end else begin
                sram_bwe = 8'h00;
            end
        end else if (fetch_go_s) begin
            sram_ce = 1'b1;
        end else begin
            sram_ce = 1'b0;
        end
    end

    // Load/store response; data and error are forced low outside lr_ack.
    always_comb begin
        lr_ack      = 1'b0;
        lr_err      = 1'b0;
        lr_rdata    = 32'h0000_0000;
        lr_isram_cs = 1'b0;
        if (!cpurst_n) begin
            lr_ack = 1'b0;
        end else begin
            case (state_q)
                ST_LS_ACC: begin
                    lr_isram_cs = 1'b1;
                    lr_ack      = we_q || err_q;
                    lr_err      = err_q;
                end
                ST_LS_RSP: begin
                    lr_isram_cs = 1'b1;
                    lr_ack      = 1'b1;
                    lr_rdata    = lane_rdata(lane_q, sram_rdata);
                end
                default: begin
                    lr_isram_cs = 1'b0;
                end
            endcase
        end
    end

    isram_rdhold u_rdhold (
        .clk      (clk),
        .cpurst_n (cpurst_n),
        .issue_i  (fetch_go_s),
        .rdata_i  (sram_rdata),
        .data_o   (instr_fromsram)
    );

endmodule

// File: tb/tb_isram_port.sv
// -----------------------------------------------------------------------------
// tb_isram_port
// Self-checking bench for isram_port: an SRAM macro model, a transaction-level
// reference model with its own golden memory, directed scenarios with literal
// expectations, then randomized fetch / load / store / reset traffic.
// -----------------------------------------------------------------------------
module tb_isram_port;

    logic        clk = 1'b0;
    logic        cpurst_n;
    logic        isram_cs;
    logic [31:3] isram_adr;
    logic [63:0] instr_fromsram;
    logic        lr_req;
    logic        lr_we;
    logic [31:2] lr_adr;
    logic [3:0]  lr_be;
    logic [31:0] lr_wdata;
    logic        lr_ack;
    logic [31:0] lr_rdata;
    logic        lr_err;
    logic        lr_isram_cs;
    logic        sram_ce;
    logic        sram_we;
    logic [12:0] sram_adr;
    logic [7:0]  sram_bwe;
    logic [63:0] sram_wdata;
    logic [63:0] sram_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    isram_port #(.ADDR_W(13), .BASE(32'h0000_0000)) dut (
        .clk(clk), .cpurst_n(cpurst_n),
        .isram_cs(isram_cs), .isram_adr(isram_adr), .instr_fromsram(instr_fromsram),
        .lr_req(lr_req), .lr_we(lr_we), .lr_adr(lr_adr), .lr_be(lr_be), .lr_wdata(lr_wdata),
        .lr_ack(lr_ack), .lr_rdata(lr_rdata), .lr_err(lr_err), .lr_isram_cs(lr_isram_cs),
        .sram_ce(sram_ce), .sram_we(sram_we), .sram_adr(sram_adr), .sram_bwe(sram_bwe),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    function automatic logic [63:0] init_word(input int i);
        if (i == 16) return 64'hA5A5_0000_1234_5678;
        if (i == 5)  return 64'h0123_4567_89AB_CDEF;
        return {32'(i) * 32'h9E37_79B9, 32'(i) ^ 32'h5A5A_0F0F};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // SRAM macro: byte-lane writes, read data registered one cycle after ce.
    logic [63:0] mem [0:8191];
    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = init_word(i);
        forever begin
            @(posedge clk);
            if (sram_ce) begin
                if (sram_we) begin
                    for (int b = 0; b < 8; b++)
                        if (sram_bwe[b]) mem[sram_adr][b*8 +: 8] = sram_wdata[b*8 +: 8];
                end else begin
                    sram_rdata <= mem[sram_adr];
                end
            end
        end
    end

    // Reference model: a load/store transaction owns the port for its access
    // cycle (plus a response cycle for an in-range read), then one slot goes
    // to fetch regardless of lr_req. Fetch data appears one cycle later and is held.
    logic [63:0] gmem [0:8191];
    int          own_pos;   // 0 not owned, 1 access cycle, 2 response cycle
    bit          gap;
    bit          t_we, t_err, t_lane;
    int          t_word;
    logic [3:0]  t_be;
    logic [31:0] t_wdata;
    logic [63:0] exp_instr;

    initial begin
        logic        e_ce, e_we, e_ack, e_err, e_own, served;
        logic [7:0]  e_bwe;
        logic [31:0] e_rd;
        int          e_adr;
        for (int i = 0; i < 8192; i++) gmem[i] = init_word(i);
        own_pos = 0; gap = 1'b0; exp_instr = 64'h0;
        forever begin
            @(negedge clk);
            e_ce = 1'b0; e_we = 1'b0; e_ack = 1'b0; e_err = 1'b0; e_own = 1'b0;
            e_bwe = 8'h00; e_rd = 32'h0; e_adr = 0; served = 1'b0;
            if (cpurst_n) begin
                if (own_pos == 1) begin
                    e_own = 1'b1;
                    if (t_err) begin
                        e_ack = 1'b1; e_err = 1'b1;
                    end else begin
                        e_ce = 1'b1; e_we = t_we; e_adr = t_word; e_ack = t_we;
                        e_bwe = t_we ? (8'(t_be) << (t_lane ? 4 : 0)) : 8'h00;
                    end
                end else if (own_pos == 2) begin
                    e_own = 1'b1; e_ack = 1'b1;
                    e_rd = t_lane ? gmem[t_word][63:32] : gmem[t_word][31:0];
                end else if (isram_cs && (gap || !lr_req)) begin
                    served = 1'b1; e_ce = 1'b1; e_adr = int'(isram_adr[15:3]);
                end
            end
            chk("sram_ce", 64'(sram_ce), 64'(e_ce));
            chk("sram_we", 64'(sram_we), 64'(e_we));
            chk("sram_bwe", 64'(sram_bwe), 64'(e_bwe));
            chk("lr_ack", 64'(lr_ack), 64'(e_ack));
            chk("lr_err", 64'(lr_err), 64'(e_err));
            chk("lr_rdata", 64'(lr_rdata), 64'(e_rd));
            chk("lr_isram_cs", 64'(lr_isram_cs), 64'(e_own));
            chk("instr_fromsram", instr_fromsram, cpurst_n ? exp_instr : 64'h0);
            if (e_ce) chk("sram_adr", 64'(sram_adr), 64'(e_adr));
            if (e_we) chk("sram_wdata", sram_wdata, {t_wdata, t_wdata});
            // advance the model to the next cycle
            if (!cpurst_n) begin
                own_pos = 0; gap = 1'b0; exp_instr = 64'h0;
            end else begin
                if (served) exp_instr = gmem[int'(isram_adr[15:3])];
                if (own_pos == 1) begin
                    if (t_we && !t_err)
                        for (int b = 0; b < 4; b++)
                            if (t_be[b]) gmem[t_word][(t_lane ? 32 : 0) + b*8 +: 8] = t_wdata[b*8 +: 8];
                    if (t_we || t_err) begin own_pos = 0; gap = 1'b1; end
                    else own_pos = 2;
                end else if (own_pos == 2) begin
                    own_pos = 0; gap = 1'b1;
                end else if (gap) begin
                    gap = 1'b0;
                end else if (lr_req) begin
                    own_pos = 1;
                    t_we = lr_we; t_be = lr_be; t_wdata = lr_wdata; t_lane = lr_adr[2];
                    t_word = int'(lr_adr[15:3]);
                    t_err = ({lr_adr, 2'b00} >= 32'h0001_0000);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic new_txn();
        lr_req   = 1'b1;
        lr_we    = 1'($urandom_range(0, 1));
        lr_be    = 4'($urandom_range(0, 15));
        lr_wdata = $urandom;
        if ($urandom_range(0, 7) == 0) lr_adr = 30'h4000 + 30'($urandom_range(0, 100000));
        else                           lr_adr = 30'($urandom_range(0, 127));
    endtask

    initial begin
        int  fcnt;
        bit  seen_ls, ack;
        cpurst_n = 1'b0; isram_cs = 1'b0; isram_adr = 29'h0;
        lr_req = 1'b0; lr_we = 1'b0; lr_adr = 30'h0; lr_be = 4'h0; lr_wdata = 32'h0;
        tick(); tick();
        @(negedge clk);
        chk("rst_instr", instr_fromsram, 64'h0);
        chk("rst_ack", 64'(lr_ack), 64'h0);
        chk("rst_own", 64'(lr_isram_cs), 64'h0);
        tick();
        cpurst_n = 1'b1;

        // fetch of word 0x10, latency 1, then held
        isram_cs = 1'b1; isram_adr = 29'h10;
        tick(); isram_cs = 1'b0;
        @(negedge clk); chk("fetch_data", instr_fromsram, 64'hA5A5_0000_1234_5678);
        tick();
        @(negedge clk); chk("fetch_hold", instr_fromsram, 64'hA5A5_0000_1234_5678);
        tick();

        // store to upper lane, then load it back
        lr_req = 1'b1; lr_we = 1'b1; lr_adr = 30'h45; lr_be = 4'b0011; lr_wdata = 32'hDEADBEEF;
        tick();
        @(negedge clk);
        chk("st_bwe", 64'(sram_bwe), 64'h30);
        chk("st_ack", 64'(lr_ack), 64'h1);
        chk("st_adr", 64'(sram_adr), 64'h22);
        tick(); lr_req = 1'b0;
        tick(); lr_req = 1'b1; lr_we = 1'b0;
        tick(); tick();
        @(negedge clk);
        chk("ld_ack", 64'(lr_ack), 64'h1);
        chk("ld_data_lo16", 64'(lr_rdata[15:0]), 64'hBEEF);
        tick(); lr_req = 1'b0;
        tick();

        // simultaneous load and fetch: load first, fetch in the gap slot
        lr_req = 1'b1; lr_we = 1'b0; lr_adr = 30'h20; isram_cs = 1'b1; isram_adr = 29'h5;
        @(negedge clk); chk("prio_no_fetch", 64'(sram_ce), 64'h0);
        tick();
        @(negedge clk); chk("prio_own1", 64'(lr_isram_cs), 64'h1);
        chk("prio_hold1", instr_fromsram, 64'hA5A5_0000_1234_5678);
        tick();
        @(negedge clk); chk("prio_own2", 64'(lr_isram_cs), 64'h1);
        chk("prio_rdata", 64'(lr_rdata), 64'h1234_5678);
        chk("prio_hold2", instr_fromsram, 64'hA5A5_0000_1234_5678);
        tick(); lr_req = 1'b0;
        @(negedge clk); chk("gap_own", 64'(lr_isram_cs), 64'h0);
        chk("gap_fetch_adr", 64'(sram_adr), 64'h5);
        chk("gap_hold", instr_fromsram, 64'hA5A5_0000_1234_5678);
        tick(); isram_cs = 1'b0;
        @(negedge clk); chk("gap_fetch_data", instr_fromsram, 64'h0123_4567_89AB_CDEF);
        tick();

        // out-of-range load
        lr_req = 1'b1; lr_we = 1'b0; lr_adr = 30'h4000;
        tick();
        @(negedge clk);
        chk("oor_ack", 64'(lr_ack), 64'h1);
        chk("oor_err", 64'(lr_err), 64'h1);
        chk("oor_rdata", 64'(lr_rdata), 64'h0);
        chk("oor_ce", 64'(sram_ce), 64'h0);
        tick(); lr_req = 1'b0;
        tick();

        // back-to-back stores with fetch held: one fetch between accesses
        isram_cs = 1'b1; isram_adr = 29'h3;
        lr_req = 1'b1; lr_we = 1'b1; lr_adr = 30'd80; lr_be = 4'hF; lr_wdata = 32'h1111_2222;
        fcnt = 0; seen_ls = 1'b0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (lr_isram_cs && sram_ce) begin
                if (seen_ls) chk("b2b_fetch_slots", 64'(fcnt), 64'd1);
                seen_ls = 1'b1; fcnt = 0;
            end else if (sram_ce) begin
                fcnt++;
            end
            ack = lr_ack;
            tick();
            if (ack) begin lr_adr = lr_adr + 30'd2; lr_wdata = lr_wdata + 32'd1; end
        end
        lr_req = 1'b0; isram_cs = 1'b0;
        tick(); tick(); tick();

        // reset during the load response abandons the transaction
        lr_req = 1'b1; lr_we = 1'b0; lr_adr = 30'h8;
        tick(); tick();
        cpurst_n = 1'b0;
        @(negedge clk);
        chk("rst_rsp_ack", 64'(lr_ack), 64'h0);
        chk("rst_rsp_rdata", 64'(lr_rdata), 64'h0);
        tick(); cpurst_n = 1'b1; lr_req = 1'b0;
        @(negedge clk);
        chk("rst_after_own", 64'(lr_isram_cs), 64'h0);
        chk("rst_after_instr", instr_fromsram, 64'h0);
        chk("rst_after_ack", 64'(lr_ack), 64'h0);
        tick();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            ack = lr_ack;
            tick();
            cpurst_n = ($urandom_range(0, 99) != 0);
            if (!cpurst_n)              lr_req = 1'b0;
            else if (lr_req && !ack)    lr_req = 1'b1;
            else if ($urandom_range(0, 2) == 0) new_txn();
            else                        lr_req = 1'b0;
            isram_cs  = ($urandom_range(0, 9) < 7);
            isram_adr = 29'($urandom_range(0, 63));
        end
        lr_req = 1'b0; isram_cs = 1'b0;
        tick(); tick();
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/isram_port.md
ISRAM_PORT -- requirements
Module: isram_port

Interface
REQ-001 Parameter ADDR_W, default 13, meaning SRAM word-address width in 64-bit words (2**13 words = 64 KB).
REQ-002 Parameter BASE, default 32'h0000_0000, meaning byte base address of the instruction SRAM.
REQ-003 The block SHALL have one clock, clk, and one reset, cpurst_n, which is synchronous and active-low.
REQ-004 Port clk  input  1  meaning: clock.
REQ-005 Port cpurst_n  input  1  meaning: synchronous active-low reset.
REQ-006 Port isram_cs  input  1  meaning: fetch read request.
REQ-007 Port isram_adr  input  29 [31:3]  meaning: fetch doubleword address.
REQ-008 Port instr_fromsram  output  64  meaning: fetch read data.
REQ-009 Port lr_req  input  1  meaning: load/store request, level, held until lr_ack.
REQ-010 Port lr_we, lr_adr[31:2], lr_be[3:0], lr_wdata[31:0]  inputs  meaning: load/store write flag, word address, byte enables, write data.
REQ-011 Port lr_ack  output  1  meaning: one-cycle completion pulse.
REQ-012 Port lr_rdata  output  32  meaning: load data, valid with lr_ack.
REQ-013 Port lr_err  output  1  meaning: out-of-range access, valid with lr_ack.
REQ-014 Port lr_isram_cs  output  1  meaning: load/store owns the port; fetch holds its data.
REQ-015 Ports sram_ce, sram_we  outputs  1; sram_adr  output  ADDR_W; sram_bwe  output  8; sram_wdata  output  64; sram_rdata  input  64  meaning: single-port synchronous SRAM macro, read data one cycle after ce.

Function
REQ-016 FSM states: IDLE, LS_ACC, LS_RSP, LS_GAP.
REQ-017 IDLE with lr_req=1 SHALL go to LS_ACC; lr_req has priority over isram_cs in the same cycle.
REQ-018 IDLE with lr_req=0 and isram_cs=1 SHALL drive sram_ce=1, sram_we=0, sram_adr=isram_adr[ADDR_W+2:3].
REQ-019 Fetch read: instr_fromsram SHALL equal sram_rdata in the cycle after the access (latency 1).
REQ-020 Outside the fetch-data cycle, instr_fromsram SHALL hold the last fetch data from an internal 64-bit register.
REQ-021 LS_ACC in range: sram_ce=1, sram_we=lr_we, sram_adr=lr_adr[ADDR_W+2:3].
REQ-022 LS_ACC write data: sram_wdata={lr_wdata,lr_wdata}; sram_bwe = lr_be in lanes [7:4] if lr_adr[2]=1, else in lanes [3:0]; the other lanes are 0.
REQ-023 LS_ACC write: lr_ack=1, then next state LS_GAP.
REQ-024 LS_ACC read: next state LS_RSP; in LS_RSP, lr_ack=1 and lr_rdata=sram_rdata[63:32] if lr_adr[2]=1, else sram_rdata[31:0]; then next state LS_GAP.
REQ-025 Out of range: any lr_adr whose byte address minus BASE is >= 2**(ADDR_W+3) SHALL produce no SRAM access, with lr_ack=1 and lr_err=1 in LS_ACC and lr_rdata=0, then LS_GAP.
REQ-026 LS_GAP SHALL serve a pending isram_cs as in IDLE, ignore lr_req, and return to IDLE; this guarantees fetch one slot between load/store accesses.
REQ-027 lr_isram_cs SHALL be 1 in LS_ACC and LS_RSP only.
REQ-028 An isram_cs arriving while lr_isram_cs=1 is not served; the fetch unit re-presents it.
REQ-029 lr_err SHALL be 0 whenever lr_ack=0.
REQ-030 lr_rdata SHALL be 0 whenever lr_ack=0.

Reset
REQ-031 With cpurst_n=0 at a clock edge: FSM=IDLE, sram_ce=0, sram_we=0, sram_bwe=0, lr_ack=0, lr_err=0, lr_rdata=0, lr_isram_cs=0, instr_fromsram=64'h0.
REQ-032 Reset mid-access SHALL abandon the transaction with no lr_ack; SRAM contents are undefined only for a write in flight.

Structure
REQ-033 State encoding and the lane-select/bwe helper SHALL live in the shared package isram_pkg.
REQ-034 The data-hold register with its capture logic SHALL be one sub-module, isram_rdhold.

Verification
REQ-035 Fetch: isram_cs=1, adr=29'h10, SRAM word 0x10=64'hA5A5_0000_1234_5678 -> instr_fromsram equals 64'hA5A5_0000_1234_5678 one cycle later.
REQ-036 Store: lr_adr=30'h45 (lr_adr[2]=1), lr_be=4'b0011, lr_wdata=32'hDEADBEEF -> sram_bwe=8'h30, lr_ack in LS_ACC; a follow-up load of the same address returns 32'hxxxxBEEF.
REQ-037 Simultaneous lr_req and isram_cs in IDLE -> lr_isram_cs=1 for 2 cycles (read), fetch served in LS_GAP; instr_fromsram holds the old value throughout.
REQ-038 Load at BASE+32'h0001_0000 with ADDR_W=13 -> lr_ack=1, lr_err=1, lr_rdata=0, sram_ce=0.
REQ-039 Back-to-back lr_req with isram_cs held high -> exactly one fetch access between every two load/store accesses.
REQ-040 cpurst_n=0 during LS_RSP -> no lr_ack; all outputs take their reset values the next cycle.
